// File: rtl/clock_display_scan.sv
// Six-digit multiplexed common-anode 7-segment driver for the clock, stopwatch or timer
// HH:MM:SS value, with frame-coherent snapshots, colon dots and timer-expiry blink.
module clock_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       stopwatch_mode,
  input  logic       timer_mode,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [4:0] stopwatch_hours,
  input  logic [5:0] stopwatch_minutes,
  input  logic [5:0] stopwatch_seconds,
  input  logic [4:0] timer_hours,
  input  logic [5:0] timer_minutes,
  input  logic [5:0] timer_seconds,
  input  logic       is_stopwatch_running,
  input  logic       is_timer_running,
  input  logic       timer_done,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [3:0] DASH = 4'd10;

  logic [TW-1:0] tick_cnt;
  logic [2:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          phase;
  logic [4:0]    snap_h;
  logic [5:0]    snap_m;
  logic [5:0]    snap_s;
  logic          snap_colon;

  logic          tick;
  logic          frame_last;
  logic          blank;
  logic [4:0]    sel_h;
  logic [5:0]    sel_m;
  logic [5:0]    sel_s;
  logic          sel_colon;
  logic [4:0]    cur_h;
  logic [5:0]    cur_m;
  logic [5:0]    cur_s;
  logic [7:0]    h_bcd;
  logic [7:0]    m_bcd;
  logic [7:0]    s_bcd;
  logic [3:0]    cur_digit;

  // Two BCD digits, or a dash pair when the field exceeds its legal maximum.
  function automatic logic [7:0] to_bcd(input logic [5:0] v, input logic [5:0] max_v);
    if (v > max_v)
      return {DASH, DASH};
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_font(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      DASH:    return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  assign tick       = (tick_cnt == TW'(SCAN_DIV - 1));
  assign frame_last = (frame_cnt == FW'(BLINK_FRAMES - 1));
  assign blank      = timer_mode & ~stopwatch_mode & timer_done & phase;

  always_comb begin
    sel_h     = hours;
    sel_m     = minutes;
    sel_s     = seconds;
    sel_colon = 1'b1;
    if (stopwatch_mode) begin
      sel_h     = stopwatch_hours;
      sel_m     = stopwatch_minutes;
      sel_s     = stopwatch_seconds;
      sel_colon = is_stopwatch_running;
    end else if (timer_mode) begin
      sel_h     = timer_hours;
      sel_m     = timer_minutes;
      sel_s     = timer_seconds;
      sel_colon = is_timer_running;
    end
  end

  // Digit 0 shows the live selection; the rest of the frame replays its snapshot.
  always_comb begin
    cur_h = snap_h;
    cur_m = snap_m;
    cur_s = snap_s;
    if (idx == 3'd0) begin
      cur_h = sel_h;
      cur_m = sel_m;
      cur_s = sel_s;
    end
  end

  assign h_bcd = to_bcd({1'b0, cur_h}, 6'd23);
  assign m_bcd = to_bcd(cur_m, 6'd59);
  assign s_bcd = to_bcd(cur_s, 6'd59);

  always_comb begin
    cur_digit = DASH;
    case (idx)
      3'd0:    cur_digit = h_bcd[7:4];
      3'd1:    cur_digit = h_bcd[3:0];
      3'd2:    cur_digit = m_bcd[7:4];
      3'd3:    cur_digit = m_bcd[3:0];
      3'd4:    cur_digit = s_bcd[7:4];
      3'd5:    cur_digit = s_bcd[3:0];
      default: cur_digit = DASH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt   <= '0;
      idx        <= 3'd0;
      frame_cnt  <= '0;
      phase      <= 1'b0;
      snap_h     <= '0;
      snap_m     <= '0;
      snap_s     <= '0;
      snap_colon <= 1'b0;
      an_n       <= 6'b111111;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        an_n  <= blank ? 6'b111111 : ~(6'b000001 << idx);
        seg_n <= seg_font(cur_digit);
        dp_n  <= blank | ~(snap_colon & ((idx == 3'd1) | (idx == 3'd3)));
        idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        if (idx == 3'd0) begin
          snap_h     <= sel_h;
          snap_m     <= sel_m;
          snap_s     <= sel_s;
          snap_colon <= sel_colon;
        end
        // Blink cadence restarts from a lit phase whenever the expiry flag drops.
        if (!timer_done) begin
          frame_cnt <= '0;
          phase     <= 1'b0;
        end else if (idx == 3'd5) begin
          if (frame_last) begin
            frame_cnt <= '0;
            phase     <= ~phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_clock_display_scan;

  logic       clk;
  logic       reset_n;
  logic       stopwatch_mode, timer_mode;
  logic [4:0] hours, stopwatch_hours, timer_hours;
  logic [5:0] minutes, seconds, stopwatch_minutes, stopwatch_seconds;
  logic [5:0] timer_minutes, timer_seconds;
  logic       is_stopwatch_running, is_timer_running, timer_done;
  logic [5:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  int n_vec = 0;
  int n_err = 0;
  logic [6:0] font [0:10];

  // digits: six nibbles, digit 0 in [23:20]; nibble 4'hA means a dash
  typedef struct {
    logic        sw;
    logic        tm;
    logic [4:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    logic        run;
    logic [23:0] digits;
    logic        colon;
  } vec_t;

  vec_t vecs [12];

  clock_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .stopwatch_mode(stopwatch_mode), .timer_mode(timer_mode),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .stopwatch_hours(stopwatch_hours), .stopwatch_minutes(stopwatch_minutes),
    .stopwatch_seconds(stopwatch_seconds),
    .timer_hours(timer_hours), .timer_minutes(timer_minutes), .timer_seconds(timer_seconds),
    .is_stopwatch_running(is_stopwatch_running), .is_timer_running(is_timer_running),
    .timer_done(timer_done),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Returns at the first falling edge on which 'target' has just become active.
  task automatic wait_an(input logic [5:0] target, input string tag);
    int n = 0;
    while (an_n === target && n < 200) begin @(negedge clk); n++; end
    while (an_n !== target && n < 200) begin @(negedge clk); n++; end
    if (an_n !== target) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: an_n %b, want %b", tag, an_n, target);
    end
  endtask

  task automatic check_digits(input logic [23:0] digits, input logic colon, input string tag);
    logic [5:0] ea;
    logic [3:0] dg;
    for (int d = 0; d < 6; d++) begin
      ea = ~(6'b000001 << d);
      dg = digits[23 - 4*d -: 4];
      chk($sformatf("%s_d%0d_an", tag, d), an_n, ea);
      chk($sformatf("%s_d%0d_seg", tag, d), seg_n, font[dg]);
      chk($sformatf("%s_d%0d_dp", tag, d), dp_n, (colon && (d == 1 || d == 3)) ? 1'b0 : 1'b1);
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic check_frame(input logic [23:0] digits, input logic colon, input string tag);
    wait_an(6'b111110, tag);
    check_digits(digits, colon, tag);
  endtask

  task automatic apply_vec(input vec_t v);
    stopwatch_mode = v.sw;
    timer_mode     = v.tm;
    if (!v.sw && !v.tm) {hours, minutes, seconds} = {v.h, v.m, v.s};
    else                {hours, minutes, seconds} = {5'd21, 6'd43, 6'd17};
    if (v.sw) {stopwatch_hours, stopwatch_minutes, stopwatch_seconds} = {v.h, v.m, v.s};
    else      {stopwatch_hours, stopwatch_minutes, stopwatch_seconds} = {5'd3, 6'd33, 6'd44};
    if (!v.sw && v.tm) {timer_hours, timer_minutes, timer_seconds} = {v.h, v.m, v.s};
    else               {timer_hours, timer_minutes, timer_seconds} = {5'd8, 6'd18, 6'd28};
    is_stopwatch_running = v.sw ? v.run : ~v.run;
    is_timer_running     = (v.tm && !v.sw) ? v.run : ~v.run;
  endtask

  initial begin
    logic [5:0] ea;

    font[0] = 7'b1000000; font[1] = 7'b1111001; font[2] = 7'b0100100;
    font[3] = 7'b0110000; font[4] = 7'b0011001; font[5] = 7'b0010010;
    font[6] = 7'b0000010; font[7] = 7'b1111000; font[8] = 7'b0000000;
    font[9] = 7'b0010000; font[10] = 7'b0111111;

    vecs[0]  = '{1'b0, 1'b0, 5'd12, 6'd34, 6'd56, 1'b0, 24'h123456, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 5'd23, 6'd59, 6'd59, 1'b0, 24'h235959, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  6'd0,  6'd0,  1'b0, 24'h000000, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 5'd0,  6'd1,  6'd5,  1'b0, 24'h000105, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 5'd9,  6'd30, 6'd7,  1'b1, 24'h093007, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 5'd1,  6'd2,  6'd3,  1'b1, 24'h010203, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 5'd10, 6'd20, 6'd30, 1'b0, 24'h102030, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 5'd12, 6'd60, 6'd5,  1'b0, 24'h12AA05, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 5'd24, 6'd0,  6'd59, 1'b0, 24'hAA0059, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 5'd31, 6'd63, 6'd63, 1'b0, 24'hAAAAAA, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 5'd5,  6'd6,  6'd7,  1'b1, 24'h050607, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 5'd0,  6'd59, 6'd60, 1'b1, 24'h0059AA, 1'b1};

    reset_n = 1'b0;
    stopwatch_mode = 1'b0; timer_mode = 1'b0;
    hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
    stopwatch_hours = '0; stopwatch_minutes = '0; stopwatch_seconds = '0;
    timer_hours = '0; timer_minutes = '0; timer_seconds = '0;
    is_stopwatch_running = 1'b0; is_timer_running = 1'b0; timer_done = 1'b0;

    // Reset state and first-digit latency
    repeat (3) @(negedge clk);
    chk("reset_an", an_n, 6'b111111);
    chk("reset_seg", seg_n, 7'h7F);
    chk("reset_dp", dp_n, 1'b1);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("startup_dark_%0d", i), an_n, 6'b111111);
    end
    @(negedge clk);
    check_digits(24'h123456, 1'b1, "first_frame");

    // Mid-frame value change does not tear the frame
    wait_an(6'b111011, "tear_d2");
    seconds = 6'd57;
    wait_an(6'b011111, "tear_d5");
    chk("tear_old_d5_seg", seg_n, font[6]);
    check_frame(24'h123457, 1'b1, "tear_next");

    for (int i = 0; i < 12; i++) begin
      apply_vec(vecs[i]);
      check_frame(vecs[i].digits, vecs[i].colon, $sformatf("v%0d", i));
    end

    // Timer-expiry blink, then drop/re-raise of timer_done
    stopwatch_mode = 1'b0; timer_mode = 1'b0;
    wait_an(6'b011111, "blink_sync");
    timer_mode = 1'b1;
    {timer_hours, timer_minutes, timer_seconds} = '0;
    is_timer_running = 1'b0;
    timer_done = 1'b1;
    repeat (4) @(negedge clk);
    for (int f = 0; f < 7; f++) begin
      for (int d = 0; d < 6; d++) begin
        ea = ((f == 2 && d == 0) || f == 6) ? 6'b111111 : ~(6'b000001 << d);
        chk($sformatf("blink_f%0d_d%0d_an", f, d), an_n, ea);
        if (f == 2 && d == 0) timer_done = 1'b0;
        if (f == 4 && d == 0) timer_done = 1'b1;
        repeat (4) @(negedge clk);
      end
    end
    timer_done = 1'b0;
    timer_mode = 1'b0;

    // Asynchronous reset in the middle of digit 3
    hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
    wait_an(6'b110111, "rst_d3");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_an", an_n, 6'b111111);
    chk("midrst_seg", seg_n, 7'h7F);
    chk("midrst_dp", dp_n, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_dark_%0d", i), an_n, 6'b111111);
    end
    @(negedge clk);
    check_digits(24'h123456, 1'b1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
